// File: rtl/mmc_pkg.sv
// Shared types and constants for the MMC DAT0 write-data transmitter.
package mmc_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StCrc   = 3'd3,
    StEnd   = 3'd4
  } mmc_state_e;

  localparam logic [15:0] Crc16Poly = 16'h1021;
  localparam int unsigned BitCntW   = 4;

  // One serial step of CRC16 (x^16+x^12+x^5+1), MSB-first feedback.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic d);
    logic fb;
    fb = d ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? Crc16Poly : 16'h0000);
  endfunction

endpackage

// File: rtl/mmc_crc16_ser.sv
// Serial CRC16 generator: one data bit per enabled cycle, synchronous clear.
module mmc_crc16_ser
  import mmc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        d,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 16'h0000;
    end else if (en) begin
      crc_d = crc16_step(crc_q, d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 16'h0000;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/mmc_dat_tx.sv
// MMC single-line write-data transmitter: start bit, block data MSB first, CRC16, end bit.
module mmc_dat_tx
  import mmc_pkg::*;
#(
  parameter int unsigned BLOCK_LEN = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_en,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] din,
  input  logic       din_vld,
  output logic       din_rdy,
  output logic       dat_o,
  output logic       dat_oe,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int unsigned ByteCntW = $clog2(BLOCK_LEN + 1);
  localparam logic [ByteCntW-1:0] BlockLenC = ByteCntW'(BLOCK_LEN);
  localparam logic [ByteCntW-1:0] LastByteC = ByteCntW'(BLOCK_LEN - 1);

  mmc_state_e          state_q, state_d;
  logic [7:0]          hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [7:0]          shift_q, shift_d;
  logic [ByteCntW-1:0] fetched_q, fetched_d;
  logic [ByteCntW-1:0] byte_cnt_q, byte_cnt_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic                dat_o_q, dat_o_d;
  logic                dat_oe_q, dat_oe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                underrun_q, underrun_d;
  logic                din_rdy_q, din_rdy_d;

  logic        accept;
  logic        byte_avail;
  logic [7:0]  next_byte;
  logic        starve;
  logic        crc_clr;
  logic        crc_en;
  logic [15:0] crc;

  assign accept     = din_vld & din_rdy_q;
  // A byte handed over on the same cycle it is needed counts as available.
  assign byte_avail = hold_full_q | accept;
  assign next_byte  = hold_full_q ? hold_q : din;

  mmc_crc16_ser u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .d     (shift_q[7]),
    .crc   (crc)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    fetched_d   = fetched_q;
    byte_cnt_d  = byte_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    dat_o_d     = dat_o_q;
    dat_oe_d    = dat_oe_q;
    done_d      = 1'b0;
    underrun_d  = 1'b0;
    crc_clr     = 1'b0;
    crc_en      = 1'b0;
    starve      = 1'b0;

    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
      fetched_d   = fetched_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        // Output enable still high here only right after the end bit.
        if (dat_oe_q) begin
          dat_oe_d = 1'b0;
          done_d   = 1'b1;
        end
        if (start) begin
          state_d     = StStart;
          crc_clr     = 1'b1;
          fetched_d   = '0;
          byte_cnt_d  = '0;
          bit_cnt_d   = '0;
          hold_full_d = 1'b0;
        end
      end
      StStart: begin
        if (bit_en) begin
          dat_o_d    = 1'b0;
          dat_oe_d   = 1'b1;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          if (byte_avail) begin
            shift_d     = next_byte;
            hold_full_d = hold_full_q & accept;
            state_d     = StData;
          end else begin
            starve = 1'b1;
          end
        end
      end
      StData: begin
        if (bit_en) begin
          dat_o_d = shift_q[7];
          shift_d = {shift_q[6:0], 1'b0};
          crc_en  = 1'b1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            if (byte_cnt_q == LastByteC) begin
              state_d = StCrc;
            end else if (byte_avail) begin
              shift_d     = next_byte;
              hold_full_d = hold_full_q & accept;
              byte_cnt_d  = byte_cnt_q + 1'b1;
            end else begin
              starve = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StCrc: begin
        if (bit_en) begin
          dat_o_d = crc[4'd15 - bit_cnt_q];
          if (bit_cnt_q == 4'd15) begin
            bit_cnt_d = '0;
            state_d   = StEnd;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StEnd: begin
        if (bit_en) begin
          dat_o_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (starve) begin
      state_d     = StIdle;
      dat_oe_d    = 1'b0;
      dat_o_d     = 1'b1;
      hold_full_d = 1'b0;
      underrun_d  = 1'b1;
    end

    if (abort) begin
      state_d     = StIdle;
      dat_oe_d    = 1'b0;
      dat_o_d     = 1'b1;
      hold_full_d = 1'b0;
      underrun_d  = 1'b0;
      done_d      = 1'b0;
      crc_clr     = 1'b0;
      crc_en      = 1'b0;
    end

    busy_d    = (state_d != StIdle);
    din_rdy_d = busy_d & ~hold_full_d & (fetched_d < BlockLenC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      fetched_q   <= '0;
      byte_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      dat_o_q     <= 1'b1;
      dat_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      din_rdy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      fetched_q   <= fetched_d;
      byte_cnt_q  <= byte_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      dat_o_q     <= dat_o_d;
      dat_oe_q    <= dat_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      din_rdy_q   <= din_rdy_d;
    end
  end

  assign din_rdy  = din_rdy_q;
  assign dat_o    = dat_o_q;
  assign dat_oe   = dat_oe_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_mmc_dat_tx.sv
// Bench for mmc_dat_tx: lane 0 is a 512-byte block at full rate, lane 1 a 4-byte block.
module tb_mmc_dat_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_n, bit_en, start, abort, din_vld;
  logic [1:0][7:0] din;
  logic rdy_b, dat_b, oe_b, busy_b, done_b, und_b;
  logic rdy_s, dat_s, oe_s, busy_s, done_s, und_s;
  wire [1:0] rdy_w  = {rdy_s, rdy_b};
  wire [1:0] dat_w  = {dat_s, dat_b};
  wire [1:0] oe_w   = {oe_s, oe_b};
  wire [1:0] done_w = {done_s, done_b};
  wire [1:0] und_w  = {und_s, und_b};

  mmc_dat_tx #(.BLOCK_LEN(512)) u_big (
    .clk(clk), .rst_n(rst_n[0]), .bit_en(bit_en[0]), .start(start[0]), .abort(abort[0]),
    .din(din[0]), .din_vld(din_vld[0]), .din_rdy(rdy_b), .dat_o(dat_b), .dat_oe(oe_b),
    .busy(busy_b), .done(done_b), .underrun(und_b)
  );

  mmc_dat_tx #(.BLOCK_LEN(4)) u_small (
    .clk(clk), .rst_n(rst_n[1]), .bit_en(bit_en[1]), .start(start[1]), .abort(abort[1]),
    .din(din[1]), .din_vld(din_vld[1]), .din_rdy(rdy_s), .dat_o(dat_s), .dat_oe(oe_s),
    .busy(busy_s), .done(done_s), .underrun(und_s)
  );

  int total = 0;
  int bad   = 0;
  logic       exp_q [2][$];
  logic [7:0] tx_q  [2][$];
  logic [7:0] blk   [$];
  int nbits [2];
  int n_done[2];
  int n_und [2];
  logic [1:0] be_prev;
  int div_cnt;
  int b1, d1, u1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic fail_to(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no event want event before timeout", name);
  endtask

  // Strobe generator: lane 0 every cycle, lane 1 every 4th cycle.
  initial begin
    bit_en  = 2'b00;
    div_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      div_cnt   = div_cnt + 1;
      bit_en[0] = 1'b1;
      bit_en[1] = (div_cnt % 4 == 0);
    end
  end

  always @(posedge clk) be_prev <= bit_en;

  // Byte source: presents the head of tx_q, pops it once the handshake completes.
  initial begin
    logic [1:0] acc;
    din_vld = 2'b00;
    din     = '0;
    forever begin
      @(negedge clk);
      acc = din_vld & rdy_w;
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
        if (acc[g] && tx_q[g].size() > 0) void'(tx_q[g].pop_front());
        din_vld[g] = (tx_q[g].size() > 0);
        din[g]     = din_vld[g] ? tx_q[g][0] : 8'h00;
      end
    end
  end

  // Monitor: each strobe with the driver enabled yields one line bit to score.
  initial begin
    for (int g = 0; g < 2; g++) begin
      nbits[g]  = 0;
      n_done[g] = 0;
      n_und[g]  = 0;
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (be_prev[g] && oe_w[g]) begin
        nbits[g]++;
        if (exp_q[g].size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_bit%0d: got bit %0b want no bit", g, dat_w[g]);
        end else begin
          chk($sformatf("line_bit%0d_%0d", g, nbits[g]), 32'(dat_w[g]), 32'(exp_q[g].pop_front()));
        end
      end
      if (done_w[g]) n_done[g]++;
      if (und_w[g]) begin
        n_und[g]++;
        chk($sformatf("und_oe%0d", g), 32'(oe_w[g]), 0);
      end
    end
  end

  function automatic logic [15:0] crc_model(input logic [7:0] b [$]);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    foreach (b[i]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = b[i][k] ^ c[15];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  task automatic exp_bits(input int g, input logic [15:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) exp_q[g].push_back(v[k]);
  endtask

  task automatic push_block(input int g, input logic [7:0] b [$], input logic [15:0] crc);
    exp_bits(g, 16'h0000, 1);
    foreach (b[i]) begin
      tx_q[g].push_back(b[i]);
      exp_bits(g, {8'h00, b[i]}, 8);
    end
    exp_bits(g, crc, 16);
    exp_bits(g, 16'h0001, 1);
  endtask

  task automatic set4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] d);
    blk.delete();
    blk.push_back(a);
    blk.push_back(b);
    blk.push_back(c);
    blk.push_back(d);
  endtask

  task automatic pulse_start(input int g);
    @(posedge clk);
    #1 start[g] = 1'b1;
    @(posedge clk);
    #1 start[g] = 1'b0;
  endtask

  // which: 0 = line bits, 1 = done pulses, 2 = underrun pulses
  function automatic int get_cnt(input int which, input int g);
    if (which == 0) return nbits[g];
    if (which == 1) return n_done[g];
    return n_und[g];
  endfunction

  task automatic wait_cnt(input int which, input int g, input int target, input string name);
    int n;
    n = 0;
    while (get_cnt(which, g) < target && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (get_cnt(which, g) < target) fail_to(name);
  endtask

  initial begin
    rst_n = 2'b00;
    start = 2'b00;
    abort = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_big",   {dat_b, oe_b, rdy_b, busy_b, done_b, und_b}, 6'b100000);
    chk("rst_small", {dat_s, oe_s, rdy_s, busy_s, done_s, und_s}, 6'b100000);
    #2 rst_n = 2'b11;

    // 512 x FF at full rate; well-known CRC16 of this block is 7FA1.
    blk.delete();
    repeat (512) blk.push_back(8'hFF);
    push_block(0, blk, 16'h7FA1);
    b1 = nbits[0];
    d1 = n_done[0];
    pulse_start(0);
    @(negedge clk);
    chk("t1_busy", 32'(busy_b), 1);
    wait_cnt(1, 0, d1 + 1, "t1_done");
    chk("t1_done_cnt", n_done[0] - d1, 1);
    chk("t1_bits", nbits[0] - b1, 1 + 8 * 512 + 16 + 1);
    chk("t1_left", exp_q[0].size(), 0);
    chk("t1_idle", {busy_b, oe_b}, 2'b00);

    // 4-byte block at quarter rate; a start in mid-transfer must be ignored.
    set4(8'h01, 8'h02, 8'h03, 8'h04);
    push_block(1, blk, crc_model(blk));
    b1 = nbits[1];
    d1 = n_done[1];
    pulse_start(1);
    wait_cnt(0, 1, b1 + 10, "t2_mid");
    pulse_start(1);
    wait_cnt(1, 1, d1 + 1, "t2_done");
    repeat (60) @(negedge clk);
    chk("t2_done_cnt", n_done[1] - d1, 1);
    chk("t2_bits", nbits[1] - b1, 50);
    chk("t2_left", exp_q[1].size(), 0);

    // Only two bytes offered: underrun at the 16th data strobe.
    tx_q[1].push_back(8'hAA);
    tx_q[1].push_back(8'h55);
    exp_bits(1, 16'h0000, 1);
    exp_bits(1, 16'h00AA, 8);
    exp_bits(1, 16'h002A, 7);
    b1 = nbits[1];
    d1 = n_done[1];
    u1 = n_und[1];
    pulse_start(1);
    wait_cnt(2, 1, u1 + 1, "t3_underrun");
    chk("t3_bits", nbits[1] - b1, 16);
    @(negedge clk);
    chk("t3_pulse", {und_s, oe_s, busy_s}, 3'b000);
    repeat (20) @(negedge clk);
    chk("t3_und_cnt", n_und[1] - u1, 1);
    chk("t3_no_done", n_done[1] - d1, 0);
    chk("t3_left", exp_q[1].size(), 0);

    // Abort in the CRC phase, then a clean block.
    set4(8'h10, 8'h20, 8'h30, 8'h40);
    push_block(1, blk, crc_model(blk));
    d1 = n_done[1];
    b1 = nbits[1];
    pulse_start(1);
    wait_cnt(0, 1, b1 + 38, "t4_crc_phase");
    @(posedge clk);
    #1 abort[1] = 1'b1;
    @(posedge clk);
    #1 abort[1] = 1'b0;
    @(negedge clk);
    chk("t4_abort", {oe_s, busy_s, dat_s}, 3'b001);
    exp_q[1].delete();
    tx_q[1].delete();
    repeat (20) @(negedge clk);
    chk("t4_no_done", n_done[1] - d1, 0);
    set4(8'hC3, 8'h3C, 8'h5A, 8'hA5);
    push_block(1, blk, crc_model(blk));
    pulse_start(1);
    wait_cnt(1, 1, d1 + 1, "t4_done");
    chk("t4_left", exp_q[1].size(), 0);

    // start together with abort in idle: nothing happens.
    d1 = n_done[1];
    u1 = n_und[1];
    @(posedge clk);
    #1 begin start[1] = 1'b1; abort[1] = 1'b1; end
    @(posedge clk);
    #1 begin start[1] = 1'b0; abort[1] = 1'b0; end
    @(negedge clk);
    chk("t5_idle", {busy_s, rdy_s, oe_s}, 3'b000);
    repeat (40) @(negedge clk);
    chk("t5_quiet", (n_done[1] - d1) + (n_und[1] - u1), 0);

    // Asynchronous reset mid-DATA, then a fresh block.
    set4(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    push_block(1, blk, crc_model(blk));
    b1 = nbits[1];
    pulse_start(1);
    wait_cnt(0, 1, b1 + 12, "t6_data_phase");
    #2 rst_n[1] = 1'b0;
    #1 chk("t6_rst", {dat_s, oe_s, rdy_s, busy_s, done_s, und_s}, 6'b100000);
    exp_q[1].delete();
    tx_q[1].delete();
    repeat (3) @(negedge clk);
    #2 rst_n[1] = 1'b1;
    d1 = n_done[1];
    set4(8'h00, 8'hFF, 8'h81, 8'h7E);
    push_block(1, blk, crc_model(blk));
    pulse_start(1);
    wait_cnt(1, 1, d1 + 1, "t6_done");
    chk("t6_left", exp_q[1].size(), 0);
    chk("t6_done_cnt", n_done[1] - d1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
